stim_sequencer: RTL and testbench

//  Synthesizable stimulus generator for the 4-bit universal shift register.

---
 rtl/stim_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_stim_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_sequencer.sv
// stim_sequencer
//   Repeatable stimulus generator for the 4-bit universal shift register.
//   One START runs a fixed sequence of segments: a parallel load, shift
//   right/left, rotate right/left and a gated segment with ENB low.
//   Data comes from a 16-bit Galois LFSR, so a run depends only on the seed
//   and on how many LFSR steps have happened since RESET.
//
// Ports
//   CLK     in   1      clock, rising edge
//   RESET   in   1      synchronous reset, active high
//   START   in   1      begin a run; only looked at in IDLE and DONE
//   ENB     out  1      DUT enable
//   DIR     out  1      DUT direction, 0 = right, 1 = left
//   MODO    out  2      DUT mode: 00 shift, 01 rotate, 10 load, 11 hold
//   S_IN    out  1      DUT serial input
//   D       out  WIDTH  DUT parallel-load data
//   SEG_ID  out  3      current segment (equals the state code below)
//   BUSY    out  1      run in progress
//   DONE    out  1      run finished; held until START or RESET
//
// All outputs are registers loaded from the next state, so each state's
// values appear on the edge that enters that state.

module stim_sequencer #(
  parameter int          WIDTH     = 4,
  parameter int          SEG_LEN   = 8,      // >= 1
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             ENB,
  output logic             DIR,
  output logic [1:0]       MODO,
  output logic             S_IN,
  output logic [WIDTH-1:0] D,
  output logic [2:0]       SEG_ID,
  output logic             BUSY,
  output logic             DONE
);

  // state   | meaning
  // --------+---------------------------------------------------------
  // S_IDLE  | after reset, waiting for START
  // S_LOAD  | one cycle parallel load of the LFSR low bits
  // S_SHR   | SEG_LEN cycles shift right, S_IN from LFSR bit 0
  // S_SHL   | SEG_LEN cycles shift left
  // S_ROTR  | SEG_LEN cycles rotate right
  // S_ROTL  | SEG_LEN cycles rotate left
  // S_GATED | SEG_LEN cycles ENB low with random controls, Q must hold
  // S_DONE  | run complete, waiting for START
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHR   = 3'd2,
    S_SHL   = 3'd3,
    S_ROTR  = 3'd4,
    S_ROTL  = 3'd5,
    S_GATED = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam int          CNT_W    = $clog2(SEG_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEG_LEN - 1);
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS     = 16'hB400;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_lfsr;
  logic             r_enb;
  logic             r_dir;
  logic [1:0]       r_modo;
  logic             r_sin;
  logic [WIDTH-1:0] r_d;
  logic [2:0]       r_seg;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      w_lfsr_nxt;
  logic [15:0]      w_lfsr_step;
  logic             w_seg_last;
  logic             w_in_seg;
  logic             w_enb;
  logic             w_dir;
  logic [1:0]       w_modo;
  logic             w_sin;
  logic [WIDTH-1:0] w_d;
  logic [2:0]       w_seg;
  logic             w_busy;
  logic             w_done;

  assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 16'h0000);
  assign w_seg_last  = (r_cnt == CNT_LAST);
  assign w_in_seg    = (r_state == S_SHR)  || (r_state == S_SHL) ||
                       (r_state == S_ROTR) || (r_state == S_ROTL) ||
                       (r_state == S_GATED);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHR;
      S_SHR:   if (w_seg_last) w_state_nxt = S_SHL;
      S_SHL:   if (w_seg_last) w_state_nxt = S_ROTR;
      S_ROTR:  if (w_seg_last) w_state_nxt = S_ROTL;
      S_ROTL:  if (w_seg_last) w_state_nxt = S_GATED;
      S_GATED: if (w_seg_last) w_state_nxt = S_DONE;
      S_DONE:  if (START) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The counter only runs inside a multi-cycle segment and restarts at 0
  // whenever the segment changes.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_in_seg && (w_state_nxt == r_state))
      w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Outputs for the state being entered, computed from the LFSR value
  // before this edge's advance.
  always_comb begin
    w_enb  = 1'b0;
    w_dir  = 1'b0;
    w_modo = 2'b11;
    w_sin  = 1'b0;
    w_d    = r_d;
    w_seg  = w_state_nxt;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (w_state_nxt)
      S_LOAD: begin
        w_enb  = 1'b1;
        w_modo = 2'b10;
        w_d    = r_lfsr[WIDTH-1:0];
        w_busy = 1'b1;
      end
      S_SHR, S_SHL: begin
        w_enb  = 1'b1;
        w_modo = 2'b00;
        w_dir  = (w_state_nxt == S_SHL);
        w_sin  = r_lfsr[0];
        w_busy = 1'b1;
      end
      S_ROTR, S_ROTL: begin
        w_enb  = 1'b1;
        w_modo = 2'b01;
        w_dir  = (w_state_nxt == S_ROTL);
        w_sin  = r_lfsr[0];
        w_busy = 1'b1;
      end
      S_GATED: begin
        w_modo = r_lfsr[1:0];
        w_dir  = r_lfsr[2];
        w_sin  = r_lfsr[3];
        w_busy = 1'b1;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The LFSR steps once for every busy cycle, including the LOAD cycle.
  assign w_lfsr_nxt = w_busy ? w_lfsr_step : r_lfsr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lfsr  <= SEED;
      r_enb   <= 1'b0;
      r_dir   <= 1'b0;
      r_modo  <= 2'b11;
      r_sin   <= 1'b0;
      r_d     <= '0;
      r_seg   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_enb   <= w_enb;
      r_dir   <= w_dir;
      r_modo  <= w_modo;
      r_sin   <= w_sin;
      r_d     <= w_d;
      r_seg   <= w_seg;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign ENB    = r_enb;
  assign DIR    = r_dir;
  assign MODO   = r_modo;
  assign S_IN   = r_sin;
  assign D      = r_d;
  assign SEG_ID = r_seg;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_stim_sequencer.sv
// Testbench for stim_sequencer: two instances (SEG_LEN 8 and SEG_LEN 1).
// Expected output vectors for a whole run are generated from the segment
// rules when START is issued and queued with the cycle they must appear on;
// a monitor pops and compares them on the falling edge.

module tb_stim_sequencer;

  typedef struct packed {
    int         cyc;
    logic       enb;
    logic       dir;
    logic [1:0] modo;
    logic       s_in;
    logic [3:0] d;
    logic [2:0] seg;
    logic       busy;
    logic       done;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic START0 = 1'b0;
  logic START1 = 1'b0;

  logic       ENB0, DIR0, S_IN0, BUSY0, DONE0;
  logic [1:0] MODO0;
  logic [3:0] D0;
  logic [2:0] SEG_ID0;
  logic       ENB1, DIR1, S_IN1, BUSY1, DONE1;
  logic [1:0] MODO1;
  logic [3:0] D1;
  logic [2:0] SEG_ID1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [15:0] m_lfsr [2];
  logic [3:0]  m_d    [2];
  bit          m_done [2];
  bit          abort_f[2];
  int          blen   [2];

  stim_sequencer #(.WIDTH(4), .SEG_LEN(8), .LFSR_SEED(16'hACE1)) dut0 (
    .CLK(CLK), .RESET(RESET), .START(START0),
    .ENB(ENB0), .DIR(DIR0), .MODO(MODO0), .S_IN(S_IN0), .D(D0),
    .SEG_ID(SEG_ID0), .BUSY(BUSY0), .DONE(DONE0)
  );

  stim_sequencer #(.WIDTH(4), .SEG_LEN(1), .LFSR_SEED(16'hACE1)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START1),
    .ENB(ENB1), .DIR(DIR1), .MODO(MODO1), .S_IN(S_IN1), .D(D1),
    .SEG_ID(SEG_ID1), .BUSY(BUSY1), .DONE(DONE1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] lstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic exp_t mk(input int c, input logic enb, input logic dir,
                              input logic [1:0] modo, input logic sin,
                              input logic [3:0] d, input logic [2:0] seg,
                              input logic busy, input logic done);
    exp_t e;
    e.cyc = c; e.enb = enb; e.dir = dir; e.modo = modo; e.s_in = sin;
    e.d = d; e.seg = seg; e.busy = busy; e.done = done;
    return e;
  endfunction

  task automatic push_exp(input int inst, input exp_t e);
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_hold(input int inst, input int c);
    push_exp(inst, mk(c, 1'b0, 1'b0, 2'b11, 1'b0, m_d[inst],
                      m_done[inst] ? 3'd7 : 3'd0, 1'b0, m_done[inst]));
  endtask

  // Whole run: load, then five segments of len cycles, then DONE.
  task automatic push_run(input int inst, input int base, output int done_c);
    int len;
    int c;
    logic [15:0] l;
    len = (inst == 0) ? 8 : 1;
    c = base;
    m_d[inst] = m_lfsr[inst][3:0];
    push_exp(inst, mk(c, 1'b1, 1'b0, 2'b10, 1'b0, m_d[inst], 3'd1, 1'b1, 1'b0));
    c++;
    m_lfsr[inst] = lstep(m_lfsr[inst]);
    for (int s = 2; s <= 6; s++) begin
      for (int k = 0; k < len; k++) begin
        l = m_lfsr[inst];
        case (s)
          2: push_exp(inst, mk(c, 1'b1, 1'b0, 2'b00, l[0], m_d[inst], 3'd2, 1'b1, 1'b0));
          3: push_exp(inst, mk(c, 1'b1, 1'b1, 2'b00, l[0], m_d[inst], 3'd3, 1'b1, 1'b0));
          4: push_exp(inst, mk(c, 1'b1, 1'b0, 2'b01, l[0], m_d[inst], 3'd4, 1'b1, 1'b0));
          5: push_exp(inst, mk(c, 1'b1, 1'b1, 2'b01, l[0], m_d[inst], 3'd5, 1'b1, 1'b0));
          default: push_exp(inst, mk(c, 1'b0, l[2], l[1:0], l[3], m_d[inst], 3'd6, 1'b1, 1'b0));
        endcase
        c++;
        m_lfsr[inst] = lstep(m_lfsr[inst]);
      end
    end
    push_exp(inst, mk(c, 1'b0, 1'b0, 2'b11, 1'b0, m_d[inst], 3'd7, 1'b0, 1'b1));
    done_c = c;
    m_done[inst] = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic cmp(input int inst, input exp_t e, input logic [13:0] act);
    logic [13:0] ev;
    ev = {e.enb, e.dir, e.modo, e.s_in, e.d, e.seg, e.busy, e.done};
    tests++;
    if (e.cyc != cyc) begin
      fails++;
      $display("FAIL dut%0d missed: expected at cyc %0d, now cyc %0d", inst, e.cyc, cyc);
    end else if (act !== ev) begin
      fails++;
      $display("FAIL dut%0d cyc %0d enb,dir,modo,sin,d,seg,busy,done: got %b required %b",
               inst, cyc, act, ev);
    end
  endtask

  logic [13:0] act0, act1;
  assign act0 = {ENB0, DIR0, MODO0, S_IN0, D0, SEG_ID0, BUSY0, DONE0};
  assign act1 = {ENB1, DIR1, MODO1, S_IN1, D1, SEG_ID1, BUSY1, DONE1};

  always @(negedge CLK) begin
    exp_t e;
    while (q0.size() > 0 && q0[0].cyc <= cyc) begin
      e = q0.pop_front();
      cmp(0, e, act0);
    end
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      cmp(1, e, act1);
    end
  end

  // Busy-window length and BUSY/DONE exclusivity.
  always @(negedge CLK) begin
    logic b, d;
    int want;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? BUSY0 : BUSY1;
      d = (i == 0) ? DONE0 : DONE1;
      want = (i == 0) ? 41 : 6;
      if (b && d) begin
        tests++;
        fails++;
        $display("FAIL dut%0d busy_done_overlap at cyc %0d: got both 1 required not both", i, cyc);
      end
      if (b === 1'b1) begin
        blen[i]++;
      end else begin
        if (blen[i] != 0 && !abort_f[i]) begin
          tests++;
          if (blen[i] != want) begin
            fails++;
            $display("FAIL dut%0d busy_length: got %0d required %0d", i, blen[i], want);
          end
        end
        blen[i] = 0;
        abort_f[i] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_start(input int inst, input logic v);
    if (inst == 0) START0 = v;
    else START1 = v;
  endtask

  task automatic do_reset(input int n);
    logic s;
    s = 1'($urandom_range(0, 1));
    RESET = 1'b1;
    START0 = s;
    START1 = s;
    while (q0.size() > 0 && q0[q0.size()-1].cyc > cyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[q1.size()-1].cyc > cyc) void'(q1.pop_back());
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] = 16'hACE1;
      m_d[i] = 4'h0;
      m_done[i] = 1'b0;
      abort_f[i] = 1'b1;
    end
    for (int k = 1; k <= n; k++) begin
      push_hold(0, cyc + 1);
      push_hold(1, cyc + 1);
      @(negedge CLK);
    end
    RESET = 1'b0;
    START0 = 1'b0;
    START1 = 1'b0;
  endtask

  task automatic idle(input int inst, input int n);
    set_start(inst, 1'b0);
    for (int k = 0; k < n; k++) begin
      push_hold(inst, cyc + 1);
      @(negedge CLK);
    end
  endtask

  // Starts a run from IDLE/DONE and returns on the cycle DONE shows
  // (or after abort_n cycles). START is random or held during the run.
  task automatic run(input int inst, input bit keep, input int abort_n, input bit chk);
    int done_c;
    set_start(inst, 1'b1);
    push_run(inst, cyc + 1, done_c);
    for (int n = 1; n <= 100; n++) begin
      @(negedge CLK);
      if (chk && n == 1) begin
        tests++;
        if ({SEG_ID0, MODO0, D0, BUSY0} !== {3'd1, 2'b10, 4'h1, 1'b1}) begin
          fails++;
          $display("FAIL first_load seg,modo,d,busy: got %b required %b",
                   {SEG_ID0, MODO0, D0, BUSY0}, {3'd1, 2'b10, 4'h1, 1'b1});
        end
      end
      if (chk && n == 2) begin
        tests++;
        if ({SEG_ID0, S_IN0} !== {3'd2, 1'b0}) begin
          fails++;
          $display("FAIL first_shift seg,s_in: got %b required %b",
                   {SEG_ID0, S_IN0}, {3'd2, 1'b0});
        end
      end
      if (n == abort_n) return;
      if (cyc >= done_c) return;
      set_start(inst, keep ? 1'b1 : 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] = 16'hACE1; m_d[i] = 4'h0; m_done[i] = 1'b0;
      abort_f[i] = 1'b0; blen[i] = 0;
    end
    @(negedge CLK);
    do_reset(2);
    idle(0, 3);
    run(0, 1'b0, -1, 1'b1);
    idle(0, 4);
    run(0, 1'b1, -1, 1'b0);
    run(0, 1'b1, -1, 1'b0);
    idle(0, 3);
    for (int r = 0; r < 4; r++) begin
      run(0, 1'b0, -1, 1'b0);
      idle(0, $urandom_range(0, 3));
    end
    // reset in the middle of the rotate-right segment
    run(0, 1'b0, 21, 1'b0);
    do_reset(1);
    run(0, 1'b0, -1, 1'b1);
    idle(0, 2);
    // single-cycle segments
    idle(1, 2);
    run(1, 1'b0, -1, 1'b0);
    idle(1, 2);
    run(1, 1'b1, -1, 1'b0);
    run(1, 1'b0, -1, 1'b0);
    idle(1, 3);
    @(negedge CLK);
    @(negedge CLK);
    tests++;
    if (q0.size() + q1.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d unchecked entries required 0", q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
